rf_wport_arbiter: RTL and testbench

Arbiter and sequencer for the single register-file write port. It shares the port between the in-order pipeline writeback stream (from the MEM→WB boundary) and a long-latency unit (multiply/divide) that returns results out of band. Pipeline writes normally win. The long-latency result waits in a one-entry buffer, and a starvation counter forces it through by holding the writeback stage. The block also produces the debug writeback trace.

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rf_arb_skid.sv | 30 +++
 rtl/rf_wport_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;
    localparam int RF_ALL_W = 38;
    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_PCW   = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [RF_PCW-1:0] pc;
        logic [RF_AW-1:0]  waddr;
        logic [RF_DW-1:0]  wdata;
    } rf_entry_t;
endpackage

// File: rtl/rf_arb_skid.sv
// One-entry holding buffer for long-latency results awaiting the write port.
module rf_arb_skid
    import rf_arb_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      push_valid,
    output logic      push_ready,
    input  rf_entry_t push_entry,
    input  logic      drain,
    output logic      full,
    output rf_entry_t entry
);
    // Handshake: an entry transfers on push_valid & push_ready; the producer
    // holds push_entry stable while push_valid is high and ready is low.
    // Ready is low while full, so a draining entry cannot be replaced that cycle.
    assign push_ready = resetn & ~full;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (push_valid && push_ready) begin
            full  <= 1'b1;
            entry <= push_entry;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between WB and the long-latency unit.
// Optional feature macro: RF_ARB_R0_FILTER_EN (suppresses writes to r0).
module rf_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wb_req_valid,
    input  logic [RF_PCW-1:0]   wb_req_pc,
    input  logic [RF_ALL_W-1:0] wb_req_rf_all,
    output logic                wb_hold,
    input  logic                ll_valid,
    output logic                ll_ready,
    input  logic [RF_PCW-1:0]   ll_pc,
    input  logic [RF_AW-1:0]    ll_waddr,
    input  logic [RF_DW-1:0]    ll_wdata,
    output logic                rf_we,
    output logic [RF_AW-1:0]    rf_waddr,
    output logic [RF_DW-1:0]    rf_wdata,
    output logic [RF_ALL_W-1:0] rf_all,
    output logic [RF_PCW-1:0]   debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [RF_AW-1:0]    debug_wb_rf_wnum,
    output logic [RF_DW-1:0]    debug_wb_rf_wdata,
    output arb_state_e          debug_arb_state
);
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       grant_wb, grant_buf, hold_c;
    logic       wb_write, ll_fire, buf_full, commit;
    rf_entry_t  wb_entry, buf_entry, sel_entry;

    assign wb_write = wb_req_valid & wb_req_rf_all[RF_ALL_W-1];
    assign wb_entry = {wb_req_pc, wb_req_rf_all[RF_ALL_W-2:0]};
    assign ll_fire  = ll_valid & ll_ready;

    rf_arb_skid u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (ll_valid),
        .push_ready (ll_ready),
        .push_entry ({ll_pc, ll_waddr, ll_wdata}),
        .drain      (grant_buf),
        .full       (buf_full),
        .entry      (buf_entry)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A non-writing WB entry never blocks the buffer; it retires alongside the drain.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_wb  = 1'b0;
        grant_buf = 1'b0;
        hold_c    = 1'b0;
        case (state_q)
            EMPTY: begin
                grant_wb = wb_write;
                if (ll_fire) state_d = PEND;
            end
            PEND: begin
                if (wb_write) begin
                    grant_wb = 1'b1;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == STARVE_MAX_C) state_d = FORCE;
                end else begin
                    grant_buf = 1'b1;
                    cnt_d     = '0;
                    state_d   = EMPTY;
                end
            end
            FORCE: begin
                grant_buf = 1'b1;
                hold_c    = wb_req_valid;
                cnt_d     = '0;
                state_d   = EMPTY;
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    assign wb_hold   = resetn & hold_c;
    assign sel_entry = grant_buf ? buf_entry : wb_entry;

`ifdef RF_ARB_R0_FILTER_EN
    assign commit = (grant_wb | grant_buf) & (sel_entry.waddr != '0);
`else
    assign commit = grant_wb | grant_buf;
`endif

    // Address/data/pc keep their last value when nothing commits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            debug_wb_pc <= '0;
        end else begin
            rf_we <= commit;
            if (commit) begin
                rf_waddr    <= sel_entry.waddr;
                rf_wdata    <= sel_entry.wdata;
                debug_wb_pc <= sel_entry.pc;
            end
        end
    end

    assign rf_all            = {rf_we, rf_waddr, rf_wdata};
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
    assign debug_arb_state   = state_q;
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios then random traffic vs a queue-based model.
module tb_rf_wport_arbiter;
    import rf_arb_pkg::*;

    localparam int unsigned STARVE_MAX = 4;
    localparam int W = 69;
`ifdef RF_ARB_R0_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_req_valid;
    logic [31:0] wb_req_pc;
    logic [37:0] wb_req_rf_all;
    logic        wb_hold;
    logic        ll_valid;
    logic        ll_ready;
    logic [31:0] ll_pc;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [37:0] rf_all;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    arb_state_e  debug_arb_state;

    rf_wport_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb_req_valid      (wb_req_valid),
        .wb_req_pc         (wb_req_pc),
        .wb_req_rf_all     (wb_req_rf_all),
        .wb_hold           (wb_hold),
        .ll_valid          (ll_valid),
        .ll_ready          (ll_ready),
        .ll_pc             (ll_pc),
        .ll_waddr          (ll_waddr),
        .ll_wdata          (ll_wdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rf_all            (rf_all),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .debug_arb_state   (debug_arb_state)
    );

    // clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: buffer occupancy, lost-arbitration count, expected output registers
    int          buf_n = 0;
    int          lost = 0;
    logic [W-1:0] m_buf = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pc = '0;
    bit          hold_last = 1'b0;
    bit          fire_last = 1'b0;
    logic        obs_hold, obs_ready;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wb(input bit v, input bit we, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] pc);
        wb_req_valid  = v;
        wb_req_rf_all = {we, a, d};
        wb_req_pc     = pc;
    endtask

    task automatic set_ll(input bit v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        ll_valid = v;
        ll_waddr = a;
        ll_wdata = d;
        ll_pc    = pc;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        bit wbw, forced, win_wb, win_buf, exp_ready, exp_hold;
        arb_state_e exp_state;
        logic [W-1:0] cand;
        logic [W-1:0] e;
        bit had;
        #2;
        wbw       = wb_req_valid && wb_req_rf_all[37];
        forced    = (buf_n == 1) && (lost == int'(STARVE_MAX));
        exp_ready = resetn && (buf_n == 0);
        exp_hold  = resetn && forced && wb_req_valid;
        exp_state = (buf_n == 0) ? EMPTY : (forced ? FORCE : PEND);
        obs_hold  = wb_hold;
        obs_ready = ll_ready;
        chk("ll_ready", 160'(ll_ready), 160'(exp_ready));
        chk("wb_hold", 160'(wb_hold), 160'(exp_hold));
        chk("state", 160'(debug_arb_state), 160'(exp_state));
        win_wb  = 1'b0;
        win_buf = 1'b0;
        if (buf_n == 0) win_wb = wbw;
        else if (forced || !wbw) win_buf = 1'b1;
        else win_wb = 1'b1;
        fire_last = ll_valid && exp_ready;
        hold_last = exp_hold;
        @(posedge clk);
        #1;
        if (!resetn) begin
            buf_n = 0; lost = 0; m_we = 0; m_addr = '0; m_data = '0; m_pc = '0;
        end else begin
            cand = win_buf ? m_buf : {wb_req_pc, wb_req_rf_all[36:0]};
            if (win_buf) begin
                buf_n = 0;
                lost  = 0;
            end else if (win_wb && buf_n == 1) begin
                lost++;
            end
            if (fire_last) begin
                buf_n = 1;
                m_buf = {ll_pc, ll_waddr, ll_wdata};
            end
            if ((win_wb || win_buf) && (!FILTER || cand[36:32] != 5'd0)) begin
                m_we = 1'b1;
                {m_pc, m_addr, m_data} = cand;
                exp_q.push_back(cand);
            end else begin
                m_we = 1'b0;
            end
        end
        chk("outputs",
            160'({rf_we, rf_waddr, rf_wdata, rf_all, debug_wb_pc, debug_wb_rf_we,
                  debug_wb_rf_wnum, debug_wb_rf_wdata}),
            160'({m_we, m_addr, m_data, m_we, m_addr, m_data, m_pc, {4{m_we}}, m_addr, m_data}));
        if (rf_we === 1'b1 || exp_q.size() != 0) begin
            had = (exp_q.size() != 0);
            e   = had ? exp_q.pop_front() : '0;
            chk("trace", 160'({rf_we, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata}), 160'({had, e}));
        end
    endtask

    initial begin
        logic [4:0] ra;
        bit prev_rst;
        resetn = 1'b0;
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        set_ll(0, 5'd0, 32'h0, 32'h0);
        cycle();
        cycle();
        chk("reset_outputs", 160'({rf_we, rf_waddr, rf_wdata, debug_wb_pc}), 160'(0));
        chk("reset_state", 160'(debug_arb_state), 160'(EMPTY));
        resetn = 1'b1;

        // lone WB write
        set_wb(1, 1, 5'd3, 32'h1234, 32'h1c000010);
        cycle();
        chk("lone_wb", 160'({rf_we, rf_waddr, rf_wdata, debug_wb_pc}), 160'({1'b1, 5'd3, 32'h1234, 32'h1c000010}));
        chk("lone_wb_hold", 160'(obs_hold), 160'(0));
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        cycle();

        // lone LL result
        set_ll(1, 5'd7, 32'hdeadbeef, 32'h1c000100);
        cycle();
        chk("lone_ll_accept", 160'({obs_ready, rf_we}), 160'({1'b1, 1'b0}));
        set_ll(0, 5'd0, 32'h0, 32'h0);
        cycle();
        chk("lone_ll_write", 160'({obs_ready, rf_we, rf_waddr, rf_wdata}), 160'({1'b0, 1'b1, 5'd7, 32'hdeadbeef}));
        cycle();
        chk("lone_ll_ready_back", 160'({obs_ready, rf_we}), 160'({1'b1, 1'b0}));

        // starvation: four WB wins, then one forced drain with WB held
        set_ll(1, 5'd9, 32'h99, 32'h1c000200);
        cycle();
        set_ll(0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_wb(1, 1, 5'(10 + i), 32'(100 + i), 32'(32'h1c000300 + 4 * i));
            cycle();
            chk("starve_wb_win", 160'({obs_hold, rf_we, rf_waddr}), 160'({1'b0, 1'b1, 5'(10 + i)}));
        end
        set_wb(1, 1, 5'd14, 32'd104, 32'h1c000310);
        cycle();
        chk("starve_force", 160'({obs_hold, rf_we, rf_waddr, debug_wb_pc}), 160'({1'b1, 1'b1, 5'd9, 32'h1c000200}));
        cycle();
        chk("starve_held_wb", 160'({obs_hold, rf_we, rf_waddr, rf_wdata}), 160'({1'b0, 1'b1, 5'd14, 32'd104}));
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        cycle();

        // WB with we=0 while buffer full
        set_ll(1, 5'd11, 32'hb00b, 32'h1c000400);
        cycle();
        set_ll(0, 5'd0, 32'h0, 32'h0);
        set_wb(1, 0, 5'd4, 32'h4444, 32'h1c000404);
        cycle();
        chk("we0_drain", 160'({obs_hold, rf_we, rf_waddr, rf_wdata}), 160'({1'b0, 1'b1, 5'd11, 32'hb00b}));
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        cycle();
        chk("we0_single", 160'(rf_we), 160'(0));

        // reset with buffer full discards the result
        set_ll(1, 5'd12, 32'hc0de, 32'h1c000500);
        cycle();
        set_ll(0, 5'd0, 32'h0, 32'h0);
        resetn = 1'b0;
        cycle();
        chk("rst_mid", 160'({obs_ready, rf_we}), 160'(0));
        resetn = 1'b1;
        cycle();
        chk("rst_release", 160'({obs_ready, rf_we}), 160'({1'b1, 1'b0}));
        cycle();
        cycle();

        // r0 write followed by a normal write
        set_wb(1, 1, 5'd0, 32'h5, 32'h1c000600);
        cycle();
        chk("r0_write", 160'(rf_we), 160'(!FILTER));
        set_wb(1, 1, 5'd5, 32'h55, 32'h1c000604);
        cycle();
        chk("after_r0", 160'({rf_we, rf_waddr, rf_wdata}), 160'({1'b1, 5'd5, 32'h55}));
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        cycle();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            prev_rst = !resetn;
            resetn = ($urandom_range(0, 149) != 0);
            if (!hold_last) begin
                ra = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 7) == 0) ra = 5'd0;
                set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, ra, $urandom(), $urandom());
            end
            if (!ll_valid || fire_last || prev_rst) begin
                set_ll($urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom(), $urandom());
            end
            cycle();
        end
        resetn = 1'b1;
        set_wb(0, 0, 5'd0, 32'h0, 32'h0);
        set_ll(0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < int'(STARVE_MAX) + 3; i++) cycle();
        chk("trace_drained", 160'(exp_q.size()), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
